// File: rtl/dmem_resp_pkg.sv
// Shared types for the multi-cycle data-memory responder.
// Holds the FSM state enum, the latched request bundle and the index-width helper.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_resp_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  function automatic int unsigned idx_w(
    input int unsigned depth
  );
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Byte-enabled single-port synchronous RAM, one access per enabled edge.
// Ports: en/we/be/idx/wd in, rd out (registered read data, held until next read).
module dmem_resp_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
          end
        end
      end else begin
        rd_q <= mem_q[idx];
      end
    end
  end

  assign rd = rd_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: req handshake, WAIT_CYCLES wait states,
// word read / byte-enabled write, rsp handshake. Ports: clk, reset (async,
// active-low), req_* in/req_ready out, rsp_valid/rsp_rdata/rsp_err out, rsp_ready in.
// Optional: DMEM_RESP_MISALIGN_CHECK_EN faults requests with addr[1:0] != 0.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IW = idx_w(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_resp_state_t state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  dmem_req_t        req_q, req_d;
  logic             err_q, err_d;
  logic             rd_ok_q, rd_ok_d;

  dmem_req_t   req_in;
  dmem_req_t   acc;
  logic        go;
  logic        below;
  logic [31:0] offset;
  logic        mis;
  logic        fault;
  logic [31:0] ram_rd;

  assign req_in = '{
    we:    req_we,
    addr:  req_addr,
    wdata: req_wdata,
    be:    req_be
  };

  // With zero wait states the access fires on the accept edge,
  // before req_q holds the request, so decode the live inputs.
  assign acc = (state_q == IDLE) ? req_in : req_q;

  // Borrow out of the subtraction flags addr < BASE_ADDR.
  assign {below, offset} = {1'b0, acc.addr} - {1'b0, BASE_ADDR};

`ifdef DMEM_RESP_MISALIGN_CHECK_EN
  assign mis = |acc.addr[1:0];
`else
  assign mis = 1'b0;
`endif

  assign fault = below | (offset >= SPAN) | mis;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    err_d     = err_q;
    rd_ok_d   = rd_ok_q;
    go        = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d = req_in;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go      = 1'b1;
          end else begin
            cnt_d   = WLOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go      = 1'b1;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          rd_ok_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (go) begin
      err_d   = fault;
      rd_ok_d = ~acc.we & ~fault;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  dmem_resp_ram #(
    .DEPTH(DEPTH_WORDS),
    .IW   (IW)
  ) u_ram (
    .clk(clk),
    .en (go),
    .we (acc.we & ~fault),
    .be (acc.be),
    .idx(offset[IW+1:2]),
    .wd (acc.wdata),
    .rd (ram_rd)
  );

  // RAM read register is not reset; gate it so writes, faults
  // and idle cycles show zero.
  assign rsp_rdata = rd_ok_q ? ram_rd : 32'h0;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of transactions plus corner sequences.
// Second instance runs with zero wait states for the back-to-back timing case.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_ready1, req_we1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_be1;
  logic        rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] rsp_rdata1;

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_responder #(
    .DEPTH_WORDS(64),
    .WAIT_CYCLES(2),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  dmem_responder #(
    .DEPTH_WORDS(64),
    .WAIT_CYCLES(0),
    .BASE_ADDR  (32'h0)
  ) dut0 (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid1),
    .req_ready(req_ready1),
    .req_we   (req_we1),
    .req_addr (req_addr1),
    .req_wdata(req_wdata1),
    .req_be   (req_be1),
    .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1),
    .rsp_err  (rsp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  int          cyc = 0;
  int          acc1[$];
  int          rsp1[$];
  logic [31:0] rdq1[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (req_valid1 && req_ready1) acc1.push_back(cyc);
    if (rsp_valid1 && rsp_ready1) begin
      rsp1.push_back(cyc);
      rdq1.push_back(rsp_rdata1);
    end
  end

  function automatic logic [31:0] pat(input int i);
    return {8'(i * 3 + 1), 8'hC3, 8'(~i), 8'(i)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic txn(input string nm, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " accept_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd3);
    chk({nm, " rdata"}, rsp_rdata, exp_rd);
    chk({nm, " err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      chk({nm, " bp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " bp_req_ready"}, 32'(req_ready), 32'd0);
      chk({nm, " bp_rdata"}, rsp_rdata, exp_rd);
      chk({nm, " bp_err"}, 32'(rsp_err), 32'(exp_err));
      req_valid = (i == 2);
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h0;
      req_be    = 4'hF;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, " valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({nm, " ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] w5;
    logic [31:0] e;
    int          n;

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    rsp_ready  = 1'b0;
    req_valid1 = 1'b0;
    req_we1    = 1'b0;
    req_addr1  = '0;
    req_wdata1 = '0;
    req_be1    = '0;
    rsp_ready1 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) begin
      txn("fill", 1'b1, 32'(i * 4), pat(i), 4'hF, 0, 32'h0, 1'b0);
    end

    w5 = {8'hAA, pat(5)[23:16], 8'hCC, pat(5)[7:0]};

    tbl.push_back('{"wr_full",   1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    tbl.push_back('{"rd_full",   1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{"wr_be5",    1'b1, 32'h10, 32'h11223344, 4'h5, 32'h0, 1'b0});
    tbl.push_back('{"rd_be5",    1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 1'b0});
    tbl.push_back('{"wr_be0",    1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0});
    tbl.push_back('{"rd_be0",    1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0});
    tbl.push_back('{"rd_oor",    1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1});
    tbl.push_back('{"wr_oor",    1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1});
    tbl.push_back('{"rd_last",   1'b0, 32'hFC, 32'h0, 4'h0, pat(63), 1'b0});
    tbl.push_back('{"rd_wrap",   1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1});
    tbl.push_back('{"wr_beA",    1'b1, 32'h14, 32'hAABBCCDD, 4'hA, 32'h0, 1'b0});
    tbl.push_back('{"rd_beA",    1'b0, 32'h14, 32'h0, 4'h0, w5, 1'b0});
`ifdef DMEM_RESP_MISALIGN_CHECK_EN
    tbl.push_back('{"rd_mis",    1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1});
`else
    tbl.push_back('{"rd_mis",    1'b0, 32'h12, 32'h0, 4'h0, 32'hDE22BE44, 1'b0});
`endif

    foreach (tbl[k]) begin
      txn(tbl[k].name, tbl[k].we, tbl[k].addr, tbl[k].wdata,
          tbl[k].be, 0, tbl[k].exp_rd, tbl[k].exp_err);
    end

    txn("bp_read", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDE22BE44, 1'b0);
    txn("after_bp", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDE22BE44, 1'b0);

    for (int i = 0; i < 64; i++) begin
      e = (i == 4) ? 32'hDE22BE44 : (i == 5) ? w5 : pat(i);
      txn("scan", 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, e, 1'b0);
    end

    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hA5A5A5A5;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst req_ready", 32'(req_ready), 32'd1);
    chk("postrst rsp_valid", 32'(rsp_valid), 32'd0);
    txn("rst_word", 1'b0, 32'h20, 32'h0, 4'h0, 0, pat(8), 1'b0);

    rsp_ready1 = 1'b1;
    req_we1    = 1'b1;
    req_addr1  = 32'h40;
    req_wdata1 = 32'h12345678;
    req_be1    = 4'hF;
    req_valid1 = 1'b1;
    n = 0;
    while (acc1.size() < 1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_we1 = 1'b0;
    n = 0;
    while (acc1.size() < 3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("w0 accept count", 32'(acc1.size()), 32'd3);
    chk("w0 rsp count", 32'(rsp1.size()), 32'd3);
    if (acc1.size() >= 3 && rsp1.size() >= 3) begin
      chk("w0 rsp1 lat", 32'(rsp1[1] - acc1[1]), 32'd1);
      chk("w0 rsp2 lat", 32'(rsp1[2] - acc1[2]), 32'd1);
      chk("w0 acc gap", 32'(acc1[2] - acc1[1]), 32'd2);
      chk("w0 rd1", rdq1[1], 32'h12345678);
      chk("w0 rd2", rdq1[2], 32'h12345678);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the processor's load/store interface.
- Accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs a word read or a byte-enabled write, and returns a response over a second valid/ready handshake.
- Sits between the core's data port (or a bus adapter) and on-chip word-addressed storage; it replaces the zero-latency dmem when memory latency is modelled.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, at least 4.
- WAIT_CYCLES, 2, wait-state cycles between request acceptance and response valid; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i]; ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  address fault.

Behaviour:
- Reset values: FSM in IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not reset.
- Reset mid-operation: any in-flight request is dropped and no memory write occurs after reset asserts.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - Latch we, addr, wdata and be.
  - If WAIT_CYCLES==0, go directly to RESP; otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle; when the counter is 0, go to RESP.
- Access timing: the memory access executes on the edge that enters RESP.
- Request acceptance to rsp_valid latency is exactly WAIT_CYCLES+1 cycles.
- Address decode:
  - offset = addr - BASE_ADDR; index = offset[log2(DEPTH_WORDS)+1:2].
  - Out of range when addr < BASE_ADDR or offset >= DEPTH_WORDS*4.
  - Out of range: rsp_err=1, rsp_rdata=0, no memory write.
- Writes: only bytes with be[i]=1 are updated. be=4'b0000 is legal and leaves memory unchanged.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On the handshake, return to IDLE; rsp_valid deasserts on the next cycle.
  - req_ready stays 0 in RESP, so no new request is accepted in the handshake cycle. Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles minimum.
- rsp_ready held low: stall indefinitely in RESP with outputs frozen.
- Request inputs may change freely while req_ready=0; they are sampled only on acceptance.
- Address bits [1:0] are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: DMEM_RESP_MISALIGN_CHECK_EN.
- Defined: a request with req_addr[1:0] != 2'b00 completes with rsp_err=1 and rsp_rdata=0; no write occurs; latency is unchanged.
- Undefined: addr[1:0] is ignored and the access goes to the enclosing word.

Decomposition:
- Package dmem_resp_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_resp_state_t;
  - a request struct (we, addr, wdata, be);
  - a localparam function for the index width, clog2(DEPTH_WORDS).
- One sub-module: dmem_resp_ram, a byte-enabled single-port synchronous RAM (we, be[3:0], idx, wd, rd), instantiated once. The FSM, counter and decode live in the top module.

Test Plan:
- Basic write/read, WAIT_CYCLES=2: write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10 → rsp_valid rises exactly 3 cycles after each acceptance; read returns 32'hDEADBEEF with rsp_err=0.
- Byte enables: with 0x10=32'hDEADBEEF, write 32'h11223344 with be=4'b0101, then read → 32'hDE22BE44.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_rdata and rsp_err stable, req_ready=0 throughout; a req_valid pulse in that window is not accepted.
- Out of range, DEPTH_WORDS=64: read 0x100 → rsp_err=1, rsp_rdata=0. Write 0x100 → no memory word changes (verify by reading all 64 words).
- WAIT_CYCLES=0 with rsp_ready held 1: two back-to-back reads → each response 1 cycle after acceptance; second acceptance 2 cycles after the first.
- Reset mid-WAIT: accept a write to 0x20 with 32'hA5A5A5A5, drive reset=0 in the first WAIT cycle, release reset → req_ready=1, rsp_valid=0, word 0x20 still holds its prior value.
  - With DMEM_RESP_MISALIGN_CHECK_EN defined, additionally: read 0x12 → rsp_err=1.
